pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side PC controller for the single-issue MIPS core. It owns the PC register and drives instruction-memory requests with a ready handshake. It holds one fetched instruction for decode and applies branch, jump and `jr` redirects. Branch and jump targets are computed internally from the held instruction and its PC+4, so decode supplies only resolution flags.

## Interface
- `RESET_PC`, default `32'h0000_3000`: PC loaded on reset.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_ready`  in  1  `imem_rdata` is valid for `imem_addr` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr_valid`  out  1  output register holds an instruction.
- `instr`  out  32  held instruction.
- `instr_pc4`  out  32  held instruction's PC+4.
- `dec_ready`  in  1  decode consumes `instr` this cycle when `instr_valid=1`.
- `is_branch`  in  1  consumed instruction is a conditional branch.
- `br_taken`  in  1  branch condition is true.
- `is_jump`  in  1  consumed instruction is `j`/`jal`.
- `is_jr`  in  1  consumed instruction is `jr`/`jalr`.
- `jr_addr`  in  32  register target for `jr`.
- `flush`  out  1  one-cycle pulse marking a discarded wrong-path fetch.

## Operation
- Accept: `acc = instr_valid & dec_ready`. The resolution inputs are sampled only on `acc`.
- Redirect: `redir = acc & (is_jump | is_jr | (is_branch & br_taken))`.
- Priority when more than one flag is set: `is_jr`, then `is_jump`, then branch.
- Targets, all arithmetic modulo 2^32:
  - Branch: `instr_pc4 + (sext(instr[15:0]) << 2)`.
  - Jump: `{instr_pc4[31:28], instr[25:0], 2'b00}`.
  - Register: `jr_addr`, used unmodified.
- FSM states:
  - RST: entered on reset; `imem_req=0`; moves to FETCH on the next clock.
  - FETCH: `imem_req=1` whenever the output register is empty or `acc=1`; otherwise `imem_req=0` and the state moves to HOLD.
  - HOLD: `imem_req=0`; returns to FETCH on the cycle `acc=1`.
- Fetch capture (`imem_req & imem_ready`, no discard):
  - `instr <= imem_rdata`, `instr_pc4 <= pc+4`, `instr_valid <= 1`, `pc <= pc+4`.
- Accept without capture: `instr_valid <= 0`.
- Reset values: `pc=RESET_PC`, `instr_valid=0`, `instr=0`, `instr_pc4=0`, `flush=0`, `imem_req=0`, pending redirect cleared, state RST.
- A reset asserted mid-operation abandons any outstanding request or pending target. A late `imem_ready` in RST is ignored.

## Timing
- Fetch latency: an instruction is on `instr` the cycle after the `imem_ready` cycle.
- With `imem_ready` tied high, one instruction is delivered per cycle. The first `instr_valid` after reset release is on cycle 2.
- Redirect without delay slot (see Configuration):
  - On the cycle after `redir`: `pc` = target.
  - `flush=1` for one cycle only if a fetch was captured in the `redir` cycle; that capture is discarded and `instr_valid` is 0.
  - The target instruction appears one cycle after its `imem_ready`.
- `imem_ready` with `imem_req=0` is ignored.
- Back-to-back redirects are legal. Each `acc` cycle is resolved independently.

## Configuration
- `PC_SEQ_DELAY_SLOT_EN`:
  - Defined: MIPS branch delay slot. The instruction at branch PC+4 is always delivered and `flush` is never asserted.
    - If the delay-slot fetch is captured in the `redir` cycle, `pc <= target`.
    - Otherwise the target goes into a pending register. The next capture, the delay slot, sets `pc <= pending` instead of `pc+4`, then clears the pending register.
  - Undefined: no delay slot; behaviour as in Timing. The pending register is not built.

## Test plan
- Reset: assert `rst` mid-fetch → `pc=32'h3000`, `instr_valid=0`, `imem_req=0`. After release, `imem_addr` sequence is 3000, 3004, 3008 with `imem_ready=1`.
- Backpressure: `dec_ready=0` for 3 cycles → `instr` stable, `imem_req=0`, `pc` frozen. On release, the next fetch resumes at the held `pc`.
- Branch, no delay slot: `beq` at 3000 with imm `16'hFFFF` taken → target `32'h3000`, `flush=1` for one cycle, next `imem_addr=3000`.
- Jump, no delay slot: `j` index `26'h0000100`, `instr_pc4=32'h3004` → `pc=32'h0000_0400`.
- `jr`, with `PC_SEQ_DELAY_SLOT_EN`: `jr` at 3000 to `32'h4000` with `imem_ready` low in the `redir` cycle → the 3004 instruction is delivered, then `imem_addr=4000`, `flush` never high.
- Priority: `is_jump=1` and `is_jr=1` in the same accept, `jr_addr=32'h5000` → `pc=32'h5000`.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory fetch bus.
//   imem_req   : fetch request (sequencer -> memory)
//   imem_addr  : fetch address (sequencer -> memory)
//   imem_ready : rdata valid for imem_addr this cycle (memory -> sequencer)
//   imem_rdata : fetched instruction word (memory -> sequencer)
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side PC controller for the single-issue MIPS core.
// Owns the PC, issues instruction-memory fetches, holds one instruction for
// decode and applies branch / jump / jr redirects using targets computed from
// the held instruction.
//
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   imem (master)           : fetch request bus (req/addr out, ready/rdata in)
//   instr_valid/instr/      : held instruction, valid flag and its PC+4
//   instr_pc4
//   dec_ready               : decode consumes instr this cycle
//   is_branch/br_taken/     : resolution flags, sampled only on accept
//   is_jump/is_jr/jr_addr
//   flush                   : one-cycle pulse when a wrong-path fetch is dropped
//
// Build option: define PC_SEQ_DELAY_SLOT_EN for MIPS branch-delay-slot
// behaviour (the instruction after a redirect is always delivered and flush
// never asserts).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               rst,
    pc_sequencer_if.master     imem,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc4,
    input  logic               dec_ready,
    input  logic               is_branch,
    input  logic               br_taken,
    input  logic               is_jump,
    input  logic               is_jr,
    input  logic [31:0]        jr_addr,
    output logic               flush
);

    typedef enum logic [1:0] {
        st_rst   = 2'd0,
        st_fetch = 2'd1,
        st_hold  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic        acc;
    logic        redir;
    logic        req;
    logic        capture;

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic        pend_valid;
    logic [31:0] pend_pc;
`endif

    assign acc       = instr_valid & dec_ready;
    assign redir     = acc & (is_jump | is_jr | (is_branch & br_taken));
    assign pc_plus4  = pc + 32'd4;
    assign br_target = instr_pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign j_target  = {instr_pc4[31:28], instr[25:0], 2'b00};
    // jr wins over jump, jump over branch.
    assign target    = is_jr ? jr_addr : (is_jump ? j_target : br_target);
    assign capture   = req & imem.imem_ready;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= st_rst;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            st_rst: begin
                state_d = st_fetch;
            end
            st_fetch: begin
                // Fetch only when the output slot is free or being freed.
                if (!instr_valid || acc) begin
                    req = 1'b1;
                end else begin
                    state_d = st_hold;
                end
            end
            st_hold: begin
                if (acc) begin
                    state_d = st_fetch;
                end
            end
            default: begin
                state_d = st_rst;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            instr_pc4   <= 32'd0;
            flush       <= 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
            pend_valid  <= 1'b0;
            pend_pc     <= 32'd0;
`endif
        end else begin
            flush <= 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
            if (redir && !capture) begin
                // Delay slot not fetched yet: park the target until it is.
                pend_valid  <= 1'b1;
                pend_pc     <= target;
                instr_valid <= 1'b0;
            end else if (capture) begin
                instr       <= imem.imem_rdata;
                instr_pc4   <= pc_plus4;
                instr_valid <= 1'b1;
                pend_valid  <= 1'b0;
                if (redir) begin
                    pc <= target;
                end else if (pend_valid) begin
                    pc <= pend_pc;
                end else begin
                    pc <= pc_plus4;
                end
            end else if (acc) begin
                instr_valid <= 1'b0;
            end
`else
            if (redir) begin
                // Any fetch captured alongside the redirect is wrong-path.
                pc          <= target;
                instr_valid <= 1'b0;
                flush       <= capture;
            end else if (capture) begin
                instr       <= imem.imem_rdata;
                instr_pc4   <= pc_plus4;
                instr_valid <= 1'b1;
                pc          <= pc_plus4;
            end else if (acc) begin
                instr_valid <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc4;
    logic        dec_ready = 1'b0;
    logic        is_branch = 1'b0;
    logic        br_taken  = 1'b0;
    logic        is_jump   = 1'b0;
    logic        is_jr     = 1'b0;
    logic [31:0] jr_addr   = 32'd0;
    logic        flush;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [0:3];

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus.master),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc4   (instr_pc4),
        .dec_ready   (dec_ready),
        .is_branch   (is_branch),
        .br_taken    (br_taken),
        .is_jump     (is_jump),
        .is_jr       (is_jr),
        .jr_addr     (jr_addr),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    // Memory: a small program at 0x3000..0x300C; elsewhere the word equals its address.
    always_comb begin
        bus.imem_rdata = bus.imem_addr;
        if (bus.imem_addr >= 32'h3000 && bus.imem_addr <= 32'h300C) begin
            bus.imem_rdata = prog[bus.imem_addr[3:2]];
        end
    end

    initial begin
        bus.imem_ready = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        is_branch = 1'b0;
        br_taken  = 1'b0;
        is_jump   = 1'b0;
        is_jr     = 1'b0;
        jr_addr   = 32'd0;
    endtask

    // Leaves the DUT in RST with reset released; the next tick enters FETCH.
    task automatic apply_reset();
        rst = 1'b1;
        clear_flags();
        dec_ready      = 1'b0;
        bus.imem_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        prog[0] = 32'h1111_1111; prog[1] = 32'h2222_2222;
        prog[2] = 32'h3333_3333; prog[3] = 32'h4444_4444;
        apply_reset();
        bus.imem_ready = 1'b1;
        tick();
        dec_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;  // asynchronous, mid-fetch
        #1;
        checks++; if (bus.imem_addr !== 32'h3000) begin errors++; $display("FAIL rst_pc: got %h want %h", bus.imem_addr, 32'h3000); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", flush); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_state_req: got %b want 0", bus.imem_req); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_late_ready: got %b want 0", instr_valid); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req: got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h3000) begin errors++; $display("FAIL seq0: got %h want %h", bus.imem_addr, 32'h3000); end
        tick();
        checks++; if (bus.imem_addr !== 32'h3004) begin errors++; $display("FAIL seq1: got %h want %h", bus.imem_addr, 32'h3004); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", instr_valid); end
        checks++; if (instr !== 32'h1111_1111) begin errors++; $display("FAIL first_instr: got %h want %h", instr, 32'h1111_1111); end
        checks++; if (instr_pc4 !== 32'h3004) begin errors++; $display("FAIL first_pc4: got %h want %h", instr_pc4, 32'h3004); end
        tick();
        checks++; if (bus.imem_addr !== 32'h3008) begin errors++; $display("FAIL seq2: got %h want %h", bus.imem_addr, 32'h3008); end
        checks++; if (instr !== 32'h2222_2222) begin errors++; $display("FAIL second_instr: got %h want %h", instr, 32'h2222_2222); end
    endtask

    task automatic test_backpressure();
        prog[0] = 32'hAAAA_0000; prog[1] = 32'hBBBB_0000;
        apply_reset();
        bus.imem_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr !== 32'hAAAA_0000) begin errors++; $display("FAIL bp_instr%0d: got %h want %h", i, instr, 32'hAAAA_0000); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req%0d: got %b want 0", i, bus.imem_req); end
            checks++; if (bus.imem_addr !== 32'h3004) begin errors++; $display("FAIL bp_pc%0d: got %h want %h", i, bus.imem_addr, 32'h3004); end
        end
        dec_ready = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL bp_resume_req: got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h3004) begin errors++; $display("FAIL bp_resume_pc: got %h want %h", bus.imem_addr, 32'h3004); end
        tick();
        checks++; if (instr !== 32'hBBBB_0000) begin errors++; $display("FAIL bp_next_instr: got %h want %h", instr, 32'hBBBB_0000); end
        checks++; if (instr_pc4 !== 32'h3008) begin errors++; $display("FAIL bp_next_pc4: got %h want %h", instr_pc4, 32'h3008); end
    endtask

`ifndef PC_SEQ_DELAY_SLOT_EN
    task automatic test_branch();
        prog[0] = 32'h1000_FFFF;  // beq $0,$0,-1
        prog[1] = 32'h5555_5555;
        apply_reset();
        bus.imem_ready = 1'b1;
        tick();
        dec_ready = 1'b1;
        tick();
        is_branch = 1'b1; br_taken = 1'b1;
        tick();
        clear_flags();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush: got %b want 1", flush); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL br_discard: got %b want 0", instr_valid); end
        checks++; if (bus.imem_addr !== 32'h3000) begin errors++; $display("FAIL br_target: got %h want %h", bus.imem_addr, 32'h3000); end
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_flush_pulse: got %b want 0", flush); end
        checks++; if (instr !== 32'h1000_FFFF) begin errors++; $display("FAIL br_tgt_instr: got %h want %h", instr, 32'h1000_FFFF); end
        is_branch = 1'b1; br_taken = 1'b0;  // not taken: falls through
        tick();
        clear_flags();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_nt_flush: got %b want 0", flush); end
        checks++; if (instr !== 32'h5555_5555) begin errors++; $display("FAIL br_nt_instr: got %h want %h", instr, 32'h5555_5555); end
        checks++; if (bus.imem_addr !== 32'h3008) begin errors++; $display("FAIL br_nt_pc: got %h want %h", bus.imem_addr, 32'h3008); end
    endtask

    task automatic test_jump();
        prog[0] = 32'h0800_0100;  // j 0x100
        apply_reset();
        bus.imem_ready = 1'b1;
        tick();
        dec_ready = 1'b1;
        tick();
        is_jump = 1'b1;
        tick();
        clear_flags();
        checks++; if (bus.imem_addr !== 32'h0000_0400) begin errors++; $display("FAIL j_target: got %h want %h", bus.imem_addr, 32'h400); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL j_flush: got %b want 1", flush); end
        tick();
        checks++; if (instr !== 32'h0000_0400) begin errors++; $display("FAIL j_tgt_instr: got %h want %h", instr, 32'h400); end
        checks++; if (instr_pc4 !== 32'h0000_0404) begin errors++; $display("FAIL j_tgt_pc4: got %h want %h", instr_pc4, 32'h404); end
    endtask

    task automatic test_redirect_no_capture();
        prog[0] = 32'h0020_0008;  // jr $1
        apply_reset();
        bus.imem_ready = 1'b1;
        tick();
        dec_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        is_jr = 1'b1; jr_addr = 32'h4000;
        tick();
        clear_flags();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jr_nocap_flush: got %b want 0", flush); end
        checks++; if (bus.imem_addr !== 32'h4000) begin errors++; $display("FAIL jr_nocap_pc: got %h want %h", bus.imem_addr, 32'h4000); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL jr_nocap_valid: got %b want 0", instr_valid); end
    endtask
`else
    task automatic test_delay_slot();
        prog[0] = 32'h0020_0008;  // jr $1
        prog[1] = 32'h6666_6666;  // delay slot
        apply_reset();
        bus.imem_ready = 1'b1;
        tick();
        dec_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        is_jr = 1'b1; jr_addr = 32'h4000;
        tick();
        clear_flags();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ds_flush0: got %b want 0", flush); end
        checks++; if (bus.imem_addr !== 32'h3004) begin errors++; $display("FAIL ds_slot_pc: got %h want %h", bus.imem_addr, 32'h3004); end
        bus.imem_ready = 1'b1;
        tick();
        checks++; if (instr !== 32'h6666_6666) begin errors++; $display("FAIL ds_slot_instr: got %h want %h", instr, 32'h6666_6666); end
        checks++; if (instr_pc4 !== 32'h3008) begin errors++; $display("FAIL ds_slot_pc4: got %h want %h", instr_pc4, 32'h3008); end
        checks++; if (bus.imem_addr !== 32'h4000) begin errors++; $display("FAIL ds_target: got %h want %h", bus.imem_addr, 32'h4000); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ds_flush1: got %b want 0", flush); end
        // Delay slot captured in the redirect cycle itself.
        apply_reset();
        bus.imem_ready = 1'b1;
        tick();
        dec_ready = 1'b1;
        tick();
        is_jr = 1'b1; jr_addr = 32'h4000;
        tick();
        clear_flags();
        checks++; if (instr !== 32'h6666_6666) begin errors++; $display("FAIL ds2_slot_instr: got %h want %h", instr, 32'h6666_6666); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ds2_valid: got %b want 1", instr_valid); end
        checks++; if (bus.imem_addr !== 32'h4000) begin errors++; $display("FAIL ds2_target: got %h want %h", bus.imem_addr, 32'h4000); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ds2_flush: got %b want 0", flush); end
    endtask
`endif

    task automatic test_priority();
        prog[0] = 32'h0800_0100;
        apply_reset();
        bus.imem_ready = 1'b1;
        tick();
        dec_ready = 1'b1;
        tick();
        is_jump = 1'b1; is_jr = 1'b1; is_branch = 1'b1; br_taken = 1'b1;
        jr_addr = 32'h5000;
        tick();
        clear_flags();
`ifdef PC_SEQ_DELAY_SLOT_EN
        checks++; if (bus.imem_addr !== 32'h5000) begin errors++; $display("FAIL prio_pc: got %h want %h", bus.imem_addr, 32'h5000); end
`else
        checks++; if (bus.imem_addr !== 32'h5000) begin errors++; $display("FAIL prio_pc: got %h want %h", bus.imem_addr, 32'h5000); end
        // Back-to-back: the target instruction is itself a taken jump.
        tick();
        checks++; if (instr !== 32'h5000) begin errors++; $display("FAIL b2b_instr: got %h want %h", instr, 32'h5000); end
        is_jr = 1'b1; jr_addr = 32'h3008;
        tick();
        clear_flags();
        checks++; if (bus.imem_addr !== 32'h3008) begin errors++; $display("FAIL b2b_pc: got %h want %h", bus.imem_addr, 32'h3008); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush: got %b want 1", flush); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_backpressure();
`ifndef PC_SEQ_DELAY_SLOT_EN
        test_branch();
        test_jump();
        test_redirect_no_capture();
`else
        test_delay_slot();
`endif
        test_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
